// File: rtl/exception_ctrl_if.sv
// rtl/exception_ctrl_if.sv - pipeline <-> exception controller signal bundle
//
// Groups the ID-stage status inputs and the redirect/flush/status outputs of
// exception_ctrl. The pipeline side uses the master modport and the controller
// uses the slave modport.
// Inputs to controller: irq, id_pc[31:0], id_valid, ex_is_ctl, id_hazard,
//                       id_eret, id_illegal (only when EXC_ILLEGAL_EN is defined)
// Outputs from controller: pc_override, pc_target[31:0], flush_if, flush_id,
//                          epc[31:0], kernel_mode, irq_ack
// Configuration macro: EXC_ILLEGAL_EN (adds id_illegal)

interface exception_ctrl_if;
    logic        irq;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        ex_is_ctl;
    logic        id_hazard;
    logic        id_eret;
`ifdef EXC_ILLEGAL_EN
    logic        id_illegal;
`endif
    logic        pc_override;
    logic [31:0] pc_target;
    logic        flush_if;
    logic        flush_id;
    logic [31:0] epc;
    logic        kernel_mode;
    logic        irq_ack;

    modport master (
`ifdef EXC_ILLEGAL_EN
        output id_illegal,
`endif
        output irq, id_pc, id_valid, ex_is_ctl, id_hazard, id_eret,
        input  pc_override, pc_target, flush_if, flush_id, epc, kernel_mode, irq_ack
    );

    modport slave (
`ifdef EXC_ILLEGAL_EN
        input  id_illegal,
`endif
        input  irq, id_pc, id_valid, ex_is_ctl, id_hazard, id_eret,
        output pc_override, pc_target, flush_if, flush_id, epc, kernel_mode, irq_ack
    );
endinterface

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - USER/KERNEL interrupt and return controller
//
// Decides in the same cycle whether the instruction in ID is squashed by an
// interrupt (redirect to the handler) or whether an eret in kernel mode
// redirects back to the saved PC.
// Ports: clk (rising-edge clock), reset (asynchronous, active-high),
//        bus (exception_ctrl_if.slave, see interface file for signal list)
// Configuration macro: EXC_ILLEGAL_EN - adds the illegal-instruction
//        exception (vector 32'h8000_0008), taking priority over irq.

module exception_ctrl (
    input  logic             clk,
    input  logic             reset,
    exception_ctrl_if.slave  bus
);
    typedef enum logic {
        ST_USER   = 1'b0,
        ST_KERNEL = 1'b1
    } state_t;

    localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
    localparam logic [31:0] ILL_VECTOR = 32'h8000_0008;

    state_t      state_q, state_d;
    logic [31:0] epc_q, epc_d;

    logic        can_trap;
    logic        irq_take;
    logic        ill_take;
    logic        exc_take;
    logic        ret;

    // A trap may only squash a real instruction that is not a delay slot and
    // not stalled; otherwise the request simply waits for a later cycle.
    always_comb begin
        can_trap = (state_q == ST_USER) && bus.id_valid && !bus.ex_is_ctl && !bus.id_hazard;
        irq_take = can_trap && bus.irq;
`ifdef EXC_ILLEGAL_EN
        ill_take = can_trap && bus.id_illegal;
`else
        ill_take = 1'b0;
`endif
        exc_take = irq_take || ill_take;
        ret      = (state_q == ST_KERNEL) && bus.id_eret && bus.id_valid;

        state_d = state_q;
        epc_d   = epc_q;
        if (exc_take) begin
            // The squashed ID instruction is the one that re-executes on return.
            state_d = ST_KERNEL;
            epc_d   = bus.id_pc;
        end else if (ret) begin
            state_d = ST_USER;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_USER;
            epc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
        end
    end

    // Redirect outputs are combinational for zero-cycle redirect latency; the
    // reset term forces them low immediately, even mid-take.
    always_comb begin
        bus.pc_override = !reset && (exc_take || ret);
        bus.flush_if    = !reset && (exc_take || ret);
        bus.flush_id    = !reset && exc_take;
        bus.irq_ack     = !reset && irq_take && !ill_take;
        if (reset) begin
            bus.pc_target = 32'h0;
        end else if (ill_take) begin
            bus.pc_target = ILL_VECTOR;
        end else if (irq_take) begin
            bus.pc_target = IRQ_VECTOR;
        end else if (ret) begin
            bus.pc_target = epc_q;
        end else begin
            bus.pc_target = 32'h0;
        end
    end

    assign bus.epc         = epc_q;
    assign bus.kernel_mode = (state_q == ST_KERNEL);
endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - self-checking bench for exception_ctrl

module tb_exception_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Reference state: which mode the processor is in and the saved PC.
    bit        m_kernel = 1'b0;
    logic [31:0] m_epc = 32'h0;

    exception_ctrl_if bus ();

    exception_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drive one cycle's ID-stage status at the falling edge, settle 1 time unit.
    task automatic drive(input bit irq, input bit valid, input bit ctl, input bit haz,
                         input bit eret, input logic [31:0] pc);
        @(negedge clk);
        bus.irq       = irq;
        bus.id_valid  = valid;
        bus.ex_is_ctl = ctl;
        bus.id_hazard = haz;
        bus.id_eret   = eret;
        bus.id_pc     = pc;
        #1;
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({bus.pc_override, bus.flush_if, bus.flush_id, bus.irq_ack, bus.kernel_mode} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {bus.pc_override, bus.flush_if, bus.flush_id, bus.irq_ack, bus.kernel_mode});
        end
        checks++;
        if (bus.epc !== 32'h0 || bus.pc_target !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: epc=%h target=%h expected 0/0", bus.epc, bus.pc_target);
        end
        @(negedge clk);
        reset = 1'b0;
        m_kernel = 1'b0;
        m_epc = 32'h0;
    endtask

    task automatic test_take();
        drive(1, 1, 0, 0, 0, 32'h0000_0040);
        checks++;
        if ({bus.pc_override, bus.flush_if, bus.flush_id, bus.irq_ack} !== 4'b1111
            || bus.pc_target !== 32'h8000_0004) begin
            errors++;
            $display("FAIL take_comb: flags=%b target=%h expected 1111/80000004",
                     {bus.pc_override, bus.flush_if, bus.flush_id, bus.irq_ack}, bus.pc_target);
        end
        post_edge();
        checks++;
        if (bus.epc !== 32'h0000_0040 || bus.kernel_mode !== 1'b1) begin
            errors++;
            $display("FAIL take_state: epc=%h kernel=%b expected 00000040/1", bus.epc, bus.kernel_mode);
        end
        // Held irq while in kernel must not ack again.
        drive(1, 1, 0, 0, 0, 32'h0000_0044);
        checks++;
        if (bus.irq_ack !== 1'b0 || bus.pc_override !== 1'b0) begin
            errors++;
            $display("FAIL kernel_no_nest: ack=%b ovr=%b expected 0/0", bus.irq_ack, bus.pc_override);
        end
        post_edge();
    endtask

    task automatic test_ret();
        drive(0, 1, 0, 0, 1, 32'h8000_0010);
        checks++;
        if ({bus.pc_override, bus.flush_if, bus.flush_id, bus.irq_ack} !== 4'b1100
            || bus.pc_target !== 32'h0000_0040) begin
            errors++;
            $display("FAIL ret_comb: flags=%b target=%h expected 1100/00000040",
                     {bus.pc_override, bus.flush_if, bus.flush_id, bus.irq_ack}, bus.pc_target);
        end
        post_edge();
        checks++;
        if (bus.kernel_mode !== 1'b0 || bus.epc !== 32'h0000_0040) begin
            errors++;
            $display("FAIL ret_state: kernel=%b epc=%h expected 0/00000040", bus.kernel_mode, bus.epc);
        end
        drive(0, 1, 0, 0, 0, 32'h0000_0044);
        checks++;
        if ({bus.pc_override, bus.flush_if, bus.flush_id} !== 3'b000 || bus.pc_target !== 32'h0) begin
            errors++;
            $display("FAIL idle_out: flags=%b target=%h expected 000/0",
                     {bus.pc_override, bus.flush_if, bus.flush_id}, bus.pc_target);
        end
        post_edge();
    endtask

    task automatic test_defer();
        drive(1, 1, 1, 0, 0, 32'h0000_0100);
        checks++;
        if ({bus.pc_override, bus.flush_if, bus.flush_id, bus.irq_ack} !== 4'b0000) begin
            errors++;
            $display("FAIL defer_ctl: flags=%b expected 0000",
                     {bus.pc_override, bus.flush_if, bus.flush_id, bus.irq_ack});
        end
        post_edge();
        drive(1, 1, 0, 1, 0, 32'h0000_0104);
        checks++;
        if ({bus.pc_override, bus.flush_if, bus.flush_id, bus.irq_ack} !== 4'b0000
            || bus.kernel_mode !== 1'b0) begin
            errors++;
            $display("FAIL defer_haz: flags=%b kernel=%b expected 0000/0",
                     {bus.pc_override, bus.flush_if, bus.flush_id, bus.irq_ack}, bus.kernel_mode);
        end
        post_edge();
        drive(1, 1, 0, 0, 0, 32'h0000_0108);
        checks++;
        if (bus.irq_ack !== 1'b1 || bus.pc_target !== 32'h8000_0004) begin
            errors++;
            $display("FAIL defer_take: ack=%b target=%h expected 1/80000004", bus.irq_ack, bus.pc_target);
        end
        post_edge();
        checks++;
        if (bus.epc !== 32'h0000_0108) begin
            errors++;
            $display("FAIL defer_epc: got %h expected 00000108", bus.epc);
        end
    endtask

    // Entered in KERNEL with epc=0x108.
    task automatic test_ret_priority();
        drive(1, 1, 0, 0, 1, 32'h8000_0020);
        checks++;
        if (bus.irq_ack !== 1'b0 || bus.flush_id !== 1'b0 || bus.pc_target !== 32'h0000_0108) begin
            errors++;
            $display("FAIL ret_wins: ack=%b flush_id=%b target=%h expected 0/0/00000108",
                     bus.irq_ack, bus.flush_id, bus.pc_target);
        end
        post_edge();
        drive(1, 1, 0, 0, 0, 32'h0000_0108);
        checks++;
        if (bus.irq_ack !== 1'b1 || bus.kernel_mode !== 1'b0) begin
            errors++;
            $display("FAIL retake: ack=%b kernel=%b expected 1/0", bus.irq_ack, bus.kernel_mode);
        end
        post_edge();
        drive(0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic test_reset_mid_take();
        // Return to USER first, then set up a take and reset during it.
        drive(0, 1, 0, 0, 1, 32'h0);
        post_edge();
        drive(1, 1, 0, 0, 0, 32'h0000_0200);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.pc_override, bus.flush_if, bus.flush_id, bus.irq_ack} !== 4'b0000
            || bus.pc_target !== 32'h0 || bus.epc !== 32'h0 || bus.kernel_mode !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_take: flags=%b target=%h epc=%h kernel=%b expected all 0",
                     {bus.pc_override, bus.flush_if, bus.flush_id, bus.irq_ack},
                     bus.pc_target, bus.epc, bus.kernel_mode);
        end
        post_edge();
        drive(0, 0, 0, 0, 0, 32'h0);
        reset = 1'b0;
        post_edge();
        checks++;
        if (bus.epc !== 32'h0 || bus.kernel_mode !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: epc=%h kernel=%b expected 0/0", bus.epc, bus.kernel_mode);
        end
        m_kernel = 1'b0;
        m_epc = 32'h0;
    endtask

`ifdef EXC_ILLEGAL_EN
    task automatic test_illegal();
        drive(1, 1, 0, 0, 0, 32'h0000_0300);
        bus.id_illegal = 1'b1;
        #1;
        checks++;
        if (bus.pc_target !== 32'h8000_0008 || bus.irq_ack !== 1'b0 || bus.flush_id !== 1'b1) begin
            errors++;
            $display("FAIL illegal_take: target=%h ack=%b flush_id=%b expected 80000008/0/1",
                     bus.pc_target, bus.irq_ack, bus.flush_id);
        end
        post_edge();
        bus.id_illegal = 1'b0;
        drive(0, 1, 0, 0, 1, 32'h0);
        post_edge();
        drive(0, 0, 0, 0, 0, 32'h0);
        m_kernel = 1'b0;
        m_epc = 32'h0000_0300;
    endtask
`endif

    // Random ID-stage traffic against a rule-level model of the two modes.
    task automatic test_random();
        bit prev_ack = 1'b0;
        for (int n = 0; n < 400; n++) begin
            bit irq   = ($urandom_range(0, 2) != 0);
            bit valid = ($urandom_range(0, 4) != 0);
            bit ctl   = ($urandom_range(0, 3) == 0);
            bit haz   = ($urandom_range(0, 3) == 0);
            bit eret  = ($urandom_range(0, 2) == 0);
            bit ill   = 1'b0;
            logic [31:0] pc = {$urandom()} & 32'hFFFF_FFFC;
            bit trap_ok, e_take_irq, e_take_ill, e_ret;
            logic [31:0] e_target;
            logic [3:0] e_flags;
            drive(irq, valid, ctl, haz, eret, pc);
`ifdef EXC_ILLEGAL_EN
            ill = ($urandom_range(0, 5) == 0);
            bus.id_illegal = ill;
            #1;
`endif
            trap_ok    = !m_kernel && valid && !ctl && !haz;
            e_take_ill = trap_ok && ill;
            e_take_irq = trap_ok && irq && !e_take_ill;
            e_ret      = m_kernel && eret && valid;
            e_target   = e_take_ill ? 32'h8000_0008 : e_take_irq ? 32'h8000_0004 :
                         e_ret ? m_epc : 32'h0;
            e_flags    = {e_take_ill || e_take_irq || e_ret, e_take_ill || e_take_irq || e_ret,
                          e_take_ill || e_take_irq, e_take_irq};
            checks++;
            if ({bus.pc_override, bus.flush_if, bus.flush_id, bus.irq_ack} !== e_flags
                || bus.pc_target !== e_target) begin
                errors++;
                $display("FAIL rand_comb[%0d]: flags=%b target=%h expected %b/%h", n,
                         {bus.pc_override, bus.flush_if, bus.flush_id, bus.irq_ack},
                         bus.pc_target, e_flags, e_target);
            end
            checks++;
            if (prev_ack && bus.irq_ack) begin
                errors++;
                $display("FAIL rand_ack_twice[%0d]: ack=%b expected 0", n, bus.irq_ack);
            end
            prev_ack = bus.irq_ack;
            if (e_take_ill || e_take_irq) begin
                m_kernel = 1'b1;
                m_epc = pc;
            end else if (e_ret) begin
                m_kernel = 1'b0;
            end
            post_edge();
            checks++;
            if (bus.kernel_mode !== m_kernel || bus.epc !== m_epc) begin
                errors++;
                $display("FAIL rand_state[%0d]: kernel=%b epc=%h expected %b/%h", n,
                         bus.kernel_mode, bus.epc, m_kernel, m_epc);
            end
        end
    endtask

    initial begin
        bus.irq = 1'b0;
        bus.id_valid = 1'b0;
        bus.ex_is_ctl = 1'b0;
        bus.id_hazard = 1'b0;
        bus.id_eret = 1'b0;
        bus.id_pc = 32'h0;
`ifdef EXC_ILLEGAL_EN
        bus.id_illegal = 1'b0;
`endif
        test_reset();
        test_take();
        test_ret();
        test_defer();
        test_ret_priority();
        test_reset_mid_take();
`ifdef EXC_ILLEGAL_EN
        test_illegal();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 irq  input  1  level timer-interrupt request from data memory peripheral block.
REQ-004 id_pc  input  32  PC of the instruction currently in ID.
REQ-005 id_valid  input  1  ID holds a real instruction (not a bubble or flushed nop).
REQ-006 ex_is_ctl  input  1  EX holds a branch/jump, so ID is a delay slot.
REQ-007 id_hazard  input  1  load-use stall active this cycle.
REQ-008 id_eret  input  1  ID decodes the return instruction (jr $26).
REQ-009 pc_override  output  1  forces next IF PC to pc_target.
REQ-010 pc_target  output  32  redirect address.
REQ-011 flush_if  output  1  converts the fetched IF instruction to nop at the IF/ID edge.
REQ-012 flush_id  output  1  converts the ID instruction to nop at the ID/EX edge.
REQ-013 epc  output  32  saved return PC.
REQ-014 kernel_mode  output  1  handler executing.
REQ-015 irq_ack  output  1  one-cycle pulse when the interrupt is taken.

Function
REQ-016 FSM states: USER (kernel_mode=0) and KERNEL (kernel_mode=1); kernel_mode is the registered state bit.
REQ-017 take = USER && irq && id_valid && !ex_is_ctl && !id_hazard, combinational.
REQ-018 On take: pc_override=1, pc_target=32'h8000_0004, flush_if=1, flush_id=1, irq_ack=1, all in the same cycle (0-cycle redirect latency).
REQ-019 On the edge ending a take cycle: epc<=id_pc and state<=KERNEL; the squashed ID instruction re-executes on return.
REQ-020 ret = KERNEL && id_eret && id_valid, combinational.
REQ-021 On ret: pc_override=1, pc_target=epc, flush_if=1, flush_id=0 (the jr itself completes harmlessly), irq_ack=0.
REQ-022 On the edge ending a ret cycle: state<=USER; epc holds its value.
REQ-023 In KERNEL, irq is ignored (no nesting), and irq_ack stays 0.
REQ-024 If irq and id_eret occur together in KERNEL, ret wins; irq is re-evaluated in USER once a valid non-delay-slot instruction reaches ID.
REQ-025 irq held while ex_is_ctl or id_hazard: take is deferred cycle by cycle, with no lost request and no partial flush.
REQ-026 When neither take nor ret is active: pc_override=0, flush_if=0, flush_id=0, pc_target=32'h0.
REQ-027 irq_ack is never high for two consecutive cycles.

Reset
REQ-028 Reset asserted at any time, including during a take or ret cycle, forces state=USER, epc=32'h0, and all outputs=0 immediately.
REQ-029 After reset deasserts, the first take is permitted on the first cycle in which REQ-017 holds.

Configuration
REQ-030 Macro EXC_ILLEGAL_EN: when defined, the block adds input id_illegal (1 bit, ID opcode undefined).
REQ-031 With EXC_ILLEGAL_EN, an illegal-instruction exception is taken in USER when id_illegal && id_valid && !ex_is_ctl && !id_hazard, using the take actions of REQ-018 with pc_target=32'h8000_0008 and irq_ack=0.
REQ-032 With EXC_ILLEGAL_EN, illegal has priority over irq in the same cycle, and id_illegal is ignored in KERNEL.
REQ-033 Without EXC_ILLEGAL_EN, the port is absent and only the irq path exists.

Verification
REQ-034 USER, irq=1, id_valid=1, id_pc=32'h0000_0040 -> same cycle pc_override=1, pc_target=32'h8000_0004, flush_if=flush_id=irq_ack=1; next cycle epc=32'h0000_0040, kernel_mode=1.
REQ-035 KERNEL, epc=32'h0000_0040, id_eret=1 -> pc_override=1, pc_target=32'h0000_0040, flush_if=1, flush_id=0; next cycle kernel_mode=0.
REQ-036 irq=1 with ex_is_ctl=1 for 1 cycle, then id_hazard=1 for 1 cycle -> no take for 2 cycles; take in cycle 3 with epc=id_pc of cycle 3.
REQ-037 KERNEL, irq=1 and id_eret=1 together -> ret only, irq_ack=0; irq still high -> take on the next cycle with id_valid=1.
REQ-038 Reset pulsed during a take cycle -> outputs 0 at once, epc=32'h0, kernel_mode=0 after release.
REQ-039 EXC_ILLEGAL_EN defined, id_illegal=1 and irq=1 in USER -> pc_target=32'h8000_0008, irq_ack=0; undefined build -> port absent, irq path unchanged.
